mlsu_shuffle_unit_mq: RTL and testbench

Matrix load shuffle unit, multi-queue generation: accepts sequential load beats from the sequential-load stage, redistributes nibbles across `NrExits` lane exits using an SEW-dependent element interleave, applies the optional mask, and stamps each beat with request ID and MRF set/bank. Each lane has its own output FIFO of configurable depth, so lanes drain independently, and the shuffle-info queue depth is a parameter. A synchronous flush and a one-hot per-request completion pulse are included. Sits between sequential-load and the MRF lane entries.

---
 rtl/mlsu_shuffle_unit_mq.sv | 200 ++++++++++++++++++++
 tb/tb_mlsu_shuffle_unit_mq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlsu_shuffle_unit_mq.sv
// Matrix load shuffle unit: interleaves sequential load nibbles across lane exits by SEW,
// applies the mask, tags each beat with request ID / MRF set / bank, and buffers per lane.
module mlsu_shuffle_unit_mq #(
    parameter int NrExits      = 4,
    parameter int NbPerLane    = 16,
    parameter int InfoDepth    = 4,
    parameter int LaneBufDepth = 2,
    parameter int NrReqIds     = 8,
    parameter int MdBits       = 3,
    parameter int SetBits      = 10,
    parameter int BankBits     = 2,
    parameter int NrSetPerMreg = 64,
    parameter int CntBits      = 8,
    localparam int IdW         = $clog2(NrReqIds)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic                                   meta_valid_i,
    output logic                                   meta_ready_o,
    input  logic [IdW-1:0]                         meta_req_id_i,
    input  logic [1:0]                             meta_sew_i,
    input  logic [MdBits-1:0]                      meta_md_i,
    input  logic                                   meta_vm_i,
    input  logic [CntBits-1:0]                     meta_cmt_cnt_i,
    input  logic                                   seq_valid_i,
    output logic                                   seq_ready_o,
    input  logic [4*NrExits*NbPerLane-1:0]         seq_nb_i,
    input  logic [NrExits*NbPerLane-1:0]           seq_en_i,
    input  logic [NrExits-1:0]                     mask_valid_i,
    input  logic [NrExits-1:0][NbPerLane-1:0]      mask_bits_i,
    output logic                                   mask_ready_o,
    output logic [NrExits-1:0]                     tx_valid_o,
    input  logic [NrExits-1:0]                     tx_ready_i,
    output logic [NrExits-1:0][4*NbPerLane-1:0]    tx_data_o,
    output logic [NrExits-1:0][NbPerLane-1:0]      tx_nbe_o,
    output logic [NrExits-1:0][IdW-1:0]            tx_req_id_o,
    output logic [NrExits-1:0][SetBits-1:0]        tx_set_o,
    output logic [NrExits-1:0][BankBits-1:0]       tx_bank_o,
    output logic [NrReqIds-1:0]                    done_o
);
    localparam int NbTot = NrExits * NbPerLane;
    localparam int IW    = $clog2(InfoDepth);
    localparam int LIW   = (LaneBufDepth > 1) ? $clog2(LaneBufDepth) : 1;
    localparam int LD    = 1 << LIW;
    localparam int BaseW = SetBits + BankBits;
    localparam logic [IW:0]      InfoOne = 1;
    localparam logic [LIW:0]     LaneOne = 1;
    localparam logic [LIW:0]     LaneCap = (LIW+1)'(LaneBufDepth);
    localparam logic [CntBits-1:0] CntOne = 1;
    localparam logic [SetBits-1:0] SetOne = 1;

    logic [IdW-1:0]      info_id_q   [InfoDepth];
    logic [1:0]          info_sew_q  [InfoDepth];
    logic                info_vm_q   [InfoDepth];
    logic [CntBits-1:0]  info_cnt_q  [InfoDepth];
    logic [SetBits-1:0]  info_set_q  [InfoDepth];
    logic [BankBits-1:0] info_bank_q [InfoDepth];
    logic [IW:0]         info_wr_q, info_wr_d, info_rd_q, info_rd_d;

    logic                info_empty, info_full, meta_fire, fire, deq;
    logic [BaseW-1:0]    meta_base;
    logic [IdW-1:0]      h_id;
    logic [1:0]          h_sew;
    logic                h_vm;
    logic [CntBits-1:0]  h_cnt;
    logic [SetBits-1:0]  h_set;
    logic [BankBits-1:0] h_bank;
    logic [NrExits-1:0]  lane_room;
    logic [NrExits-1:0][4*NbPerLane-1:0] sh_data;
    logic [NrExits-1:0][NbPerLane-1:0]   sh_nbe;

    assign info_empty = (info_wr_q == info_rd_q);
    assign info_full  = (info_wr_q[IW-1:0] == info_rd_q[IW-1:0]) && (info_wr_q[IW] != info_rd_q[IW]);
    assign meta_ready_o = !info_full && !flush_i;
    assign meta_fire    = meta_valid_i && meta_ready_o;
    assign meta_base    = BaseW'(meta_md_i) * BaseW'(NrSetPerMreg);

    assign h_id   = info_id_q[info_rd_q[IW-1:0]];
    assign h_sew  = info_sew_q[info_rd_q[IW-1:0]];
    assign h_vm   = info_vm_q[info_rd_q[IW-1:0]];
    assign h_cnt  = info_cnt_q[info_rd_q[IW-1:0]];
    assign h_set  = info_set_q[info_rd_q[IW-1:0]];
    assign h_bank = info_bank_q[info_rd_q[IW-1:0]];

    // Lane occupancy is count-based: a pop in the same cycle does not free a slot early.
    assign seq_ready_o  = !flush_i && !info_empty && (&lane_room) && (h_vm || (&mask_valid_i));
    assign fire         = seq_valid_i && seq_ready_o;
    assign deq          = fire && (h_cnt == '0);
    assign mask_ready_o = fire && !h_vm;
    assign done_o       = deq ? (NrReqIds'(1) << h_id) : '0;

    always_comb begin
        info_wr_d = info_wr_q;
        info_rd_d = info_rd_q;
        if (flush_i) begin
            info_wr_d = '0;
            info_rd_d = '0;
        end else begin
            if (meta_fire) info_wr_d = info_wr_q + InfoOne;
            if (deq)       info_rd_d = info_rd_q + InfoOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            info_wr_q <= '0;
            info_rd_q <= '0;
        end else begin
            info_wr_q <= info_wr_d;
            info_rd_q <= info_rd_d;
        end
    end

    // A non-final beat advances the head's set and remaining count in place.
    always_ff @(posedge clk_i) begin
        if (meta_fire) begin
            info_id_q[info_wr_q[IW-1:0]]   <= meta_req_id_i;
            info_sew_q[info_wr_q[IW-1:0]]  <= meta_sew_i;
            info_vm_q[info_wr_q[IW-1:0]]   <= meta_vm_i;
            info_cnt_q[info_wr_q[IW-1:0]]  <= meta_cmt_cnt_i;
            info_set_q[info_wr_q[IW-1:0]]  <= meta_base[BaseW-1:BankBits];
            info_bank_q[info_wr_q[IW-1:0]] <= meta_base[BankBits-1:0];
        end
        if (fire && (h_cnt != '0)) begin
            info_cnt_q[info_rd_q[IW-1:0]] <= h_cnt - CntOne;
            info_set_q[info_rd_q[IW-1:0]] <= h_set + SetOne;
        end
    end

    // Element e of EW nibbles goes to lane e % NrExits, slot e / NrExits.
    always_comb begin
        int ew;
        int s;
        sh_data = '0;
        sh_nbe  = '0;
        ew = 2 << h_sew;
        for (int l = 0; l < NrExits; l++) begin
            for (int o = 0; o < NbPerLane; o++) begin
                s = (o / ew) * ew * NrExits + l * ew + (o % ew);
                if (s < NbTot) begin
                    sh_data[l][4*o +: 4] = seq_nb_i[4*s +: 4];
                    sh_nbe[l][o]         = seq_en_i[s] && (h_vm || mask_bits_i[l][o]);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NrExits; gi++) begin : g_lane
        logic [LIW:0]           wr_q, wr_d, rd_q, rd_d;
        logic [4*NbPerLane-1:0] data_q [LD];
        logic [NbPerLane-1:0]   nbe_q  [LD];
        logic [IdW-1:0]         id_q   [LD];
        logic [SetBits-1:0]     set_q  [LD];
        logic [BankBits-1:0]    bank_q [LD];
        logic                   pop;

        assign pop = tx_valid_o[gi] && tx_ready_i[gi];

        always_comb begin
            wr_d = wr_q;
            rd_d = rd_q;
            if (flush_i) begin
                wr_d = '0;
                rd_d = '0;
            end else begin
                if (fire) wr_d = wr_q + LaneOne;
                if (pop)  rd_d = rd_q + LaneOne;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                wr_q <= wr_d;
                rd_q <= rd_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (fire) begin
                data_q[wr_q[LIW-1:0]] <= sh_data[gi];
                nbe_q[wr_q[LIW-1:0]]  <= sh_nbe[gi];
                id_q[wr_q[LIW-1:0]]   <= h_id;
                set_q[wr_q[LIW-1:0]]  <= h_set;
                bank_q[wr_q[LIW-1:0]] <= h_bank;
            end
        end

        assign lane_room[gi]   = ((wr_q - rd_q) < LaneCap);
        assign tx_valid_o[gi]  = (wr_q != rd_q);
        assign tx_data_o[gi]   = data_q[rd_q[LIW-1:0]];
        assign tx_nbe_o[gi]    = nbe_q[rd_q[LIW-1:0]];
        assign tx_req_id_o[gi] = id_q[rd_q[LIW-1:0]];
        assign tx_set_o[gi]    = set_q[rd_q[LIW-1:0]];
        assign tx_bank_o[gi]   = bank_q[rd_q[LIW-1:0]];
    end
endmodule

// File: tb/tb_mlsu_shuffle_unit_mq.sv
// Directed bench for mlsu_shuffle_unit_mq: stimulus pushes expected lane beats into
// per-lane queues, a negedge monitor pops and compares whenever a lane hands off a beat.
module tb_mlsu_shuffle_unit_mq;
    typedef struct {
        logic [63:0] data;
        logic [15:0] nbe;
        logic [2:0]  id;
        logic [9:0]  set;
        logic [1:0]  bank;
    } lane_t;

    typedef struct {
        int id;
        int sew;
        int vm;
        int cnt;
        int set;
    } meta_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             meta_valid = 1'b0;
    logic             meta_ready;
    logic [2:0]       meta_id = '0;
    logic [1:0]       meta_sew = '0;
    logic [2:0]       meta_md = '0;
    logic             meta_vm = 1'b0;
    logic [7:0]       meta_cnt = '0;
    logic             seq_valid = 1'b0;
    logic             seq_ready;
    logic [255:0]     seq_nb = '0;
    logic [63:0]      seq_en = '0;
    logic [3:0]       mask_valid = '0;
    logic [3:0][15:0] mask_bits = '0;
    logic             mask_ready;
    logic [3:0]       tx_valid;
    logic [3:0]       tx_ready = '0;
    logic [3:0][63:0] tx_data;
    logic [3:0][15:0] tx_nbe;
    logic [3:0][2:0]  tx_id;
    logic [3:0][9:0]  tx_set;
    logic [3:0][1:0]  tx_bank;
    logic [7:0]       done;

    int total = 0;
    int bad = 0;
    lane_t exp_q[4][$];
    meta_t info_m[$];

    mlsu_shuffle_unit_mq dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .meta_valid_i(meta_valid), .meta_ready_o(meta_ready),
        .meta_req_id_i(meta_id), .meta_sew_i(meta_sew), .meta_md_i(meta_md),
        .meta_vm_i(meta_vm), .meta_cmt_cnt_i(meta_cnt),
        .seq_valid_i(seq_valid), .seq_ready_o(seq_ready),
        .seq_nb_i(seq_nb), .seq_en_i(seq_en),
        .mask_valid_i(mask_valid), .mask_bits_i(mask_bits), .mask_ready_o(mask_ready),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_data_o(tx_data), .tx_nbe_o(tx_nbe), .tx_req_id_o(tx_id),
        .tx_set_o(tx_set), .tx_bank_o(tx_bank), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [255:0] ramp();
        logic [255:0] r;
        for (int k = 0; k < 64; k++) r[4*k +: 4] = 4'(k % 16);
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_meta(input int id, input int sew, input int md, input int vm, input int cnt);
        bit got = 0;
        meta_t m;
        meta_valid = 1'b1;
        meta_id = 3'(id); meta_sew = 2'(sew); meta_md = 3'(md);
        meta_vm = 1'(vm); meta_cnt = 8'(cnt);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (meta_ready) begin got = 1; break; end
        end
        if (!got) chk("meta_timeout", 64'd0, 64'd1);
        else begin
            m.id = id; m.sew = sew; m.vm = vm; m.cnt = cnt; m.set = (md * 64 / 4) % 1024;
            info_m.push_back(m);
            $display("meta id=%0d sew=%0d md=%0d vm=%0d cnt=%0d", id, sew, md, vm, cnt);
        end
        @(posedge clk); #1;
        meta_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [255:0] nb, input logic [63:0] en);
        seq_valid = 1'b1;
        seq_nb = nb;
        seq_en = en;
    endtask

    // Waits for the beat to fire, checks the fire-cycle outputs and queues the lane beats.
    task automatic wait_fire(input string tag, input int exp_mrdy, output int waited);
        bit got = 0;
        meta_t h;
        lane_t e[4];
        int ew, el, ln, o;
        waited = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (seq_ready) begin got = 1; waited = n; break; end
        end
        if (!got || info_m.size() == 0) chk({tag, "_fire_timeout"}, 64'd0, 64'd1);
        else begin
            h = info_m[0];
            chk({tag, "_done"}, 64'(done), (h.cnt == 0) ? 64'(8'd1 << h.id) : 64'd0);
            chk({tag, "_mask_ready"}, 64'(mask_ready), 64'(h.vm == 0));
            if (exp_mrdy >= 0) chk({tag, "_meta_ready"}, 64'(meta_ready), 64'(exp_mrdy));
            for (int l = 0; l < 4; l++) begin
                e[l].data = '0; e[l].nbe = '0;
                e[l].id = 3'(h.id); e[l].set = 10'(h.set); e[l].bank = 2'd0;
            end
            ew = 2 << h.sew;
            for (int s = 0; s < 64; s++) begin
                el = s / ew;
                ln = el % 4;
                o  = (el / 4) * ew + s % ew;
                if (o < 16) begin
                    e[ln].data[4*o +: 4] = seq_nb[4*s +: 4];
                    e[ln].nbe[o] = seq_en[s] & ((h.vm != 0) | mask_bits[ln][o]);
                end
            end
            for (int l = 0; l < 4; l++) exp_q[l].push_back(e[l]);
            if (h.cnt == 0) void'(info_m.pop_front());
            else begin
                info_m[0].cnt = h.cnt - 1;
                info_m[0].set = (h.set + 1) % 1024;
            end
        end
        @(posedge clk); #1;
        seq_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        lane_t e;
        if (rst_n) begin
            for (int l = 0; l < 4; l++) begin
                if (tx_valid[l] && tx_ready[l]) begin
                    if (exp_q[l].size() == 0) chk($sformatf("lane%0d_unexpected_beat", l), 64'd1, 64'd0);
                    else begin
                        e = exp_q[l].pop_front();
                        chk($sformatf("lane%0d_data", l), tx_data[l], e.data);
                        chk($sformatf("lane%0d_nbe", l), 64'(tx_nbe[l]), 64'(e.nbe));
                        chk($sformatf("lane%0d_id", l), 64'(tx_id[l]), 64'(e.id));
                        chk($sformatf("lane%0d_set", l), 64'(tx_set[l]), 64'(e.set));
                        chk($sformatf("lane%0d_bank", l), 64'(tx_bank[l]), 64'(e.bank));
                        $display("lane %0d beat id=%0d set=%0d bank=%0d data=%h nbe=%h",
                                 l, tx_id[l], tx_set[l], tx_bank[l], tx_data[l], tx_nbe[l]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_meta_ready", 64'(meta_ready), 64'd1);
        chk("rst_seq_ready", 64'(seq_ready), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_mask_ready", 64'(mask_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;

        // Single beat, sew=32b, md=1
        tx_ready = 4'hF;
        send_meta(0, 2, 1, 1, 0);
        drive_beat(ramp(), '1);
        wait_fire("t1", -1, w);
        chk("t1_meta_to_fire_latency", 64'(w), 64'd0);
        @(negedge clk);
        chk("t1_tx_valid", 64'(tx_valid), 64'hF);
        chk("t1_l1_nb0", 64'(tx_data[1][3:0]), 64'd8);
        chk("t1_l0_nb8", 64'(tx_data[0][35:32]), 64'd0);
        chk("t1_l2_nb9", 64'(tx_data[2][39:36]), 64'd1);
        chk("t1_set", 64'(tx_set[1]), 64'd16);
        chk("t1_bank", 64'(tx_bank[1]), 64'd0);
        @(posedge clk); #1;

        // Four-beat request, sew=8b
        send_meta(3, 0, 1, 1, 3);
        for (int b = 0; b < 4; b++) begin
            drive_beat(rnd256(), {$urandom, $urandom});
            wait_fire("t2", -1, w);
        end
        repeat (2) @(posedge clk); #1;

        // Masked request waits for all mask lanes
        send_meta(5, 1, 2, 0, 0);
        mask_valid = 4'b0111;
        mask_bits = {16'hF0F0, 16'h3C3C, 16'hAAAA, 16'h00FF};
        drive_beat(rnd256(), '1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("t3_mask_wait_seq_ready", 64'(seq_ready), 64'd0);
        end
        @(posedge clk); #1;
        mask_valid = 4'hF;
        wait_fire("t3", -1, w);
        chk("t3_fire_latency", 64'(w), 64'd0);
        @(negedge clk);
        chk("t3_l0_nbe", 64'(tx_nbe[0]), 64'h00FF);
        @(posedge clk); #1;
        mask_valid = 4'h0;

        // Lane 2 back-pressure with depth-2 lane buffers
        send_meta(2, 3, 3, 1, 2);
        tx_ready = 4'b1011;
        drive_beat(rnd256(), {$urandom, $urandom});
        wait_fire("t4a", -1, w);
        drive_beat(rnd256(), {$urandom, $urandom});
        wait_fire("t4b", -1, w);
        drive_beat(rnd256(), {$urandom, $urandom});
        @(negedge clk);
        chk("t4_full_seq_ready", 64'(seq_ready), 64'd0);
        chk("t4_l2_valid", 64'(tx_valid[2]), 64'd1);
        @(negedge clk);
        chk("t4_l0_drained", 64'(tx_valid[0]), 64'd0);
        chk("t4_full_seq_ready2", 64'(seq_ready), 64'd0);
        @(posedge clk); #1;
        tx_ready = 4'hF;
        @(negedge clk);
        chk("t4_pop_same_cycle_seq_ready", 64'(seq_ready), 64'd0);
        wait_fire("t4c", -1, w);
        chk("t4_third_fire_latency", 64'(w), 64'd0);
        repeat (4) @(posedge clk); #1;

        // Info queue full, dequeue, wrap
        tx_ready = 4'h0;
        send_meta(1, 2, 4, 1, 0);
        send_meta(2, 2, 5, 1, 0);
        send_meta(3, 2, 6, 1, 0);
        send_meta(4, 2, 7, 1, 0);
        @(negedge clk);
        chk("t5_info_full", 64'(meta_ready), 64'd0);
        @(posedge clk); #1;
        drive_beat(rnd256(), '1);
        wait_fire("t5a", 0, w);
        @(negedge clk);
        chk("t5_ready_after_deq", 64'(meta_ready), 64'd1);
        @(posedge clk); #1;
        send_meta(6, 2, 0, 1, 0);
        drive_beat(rnd256(), '1);
        wait_fire("t5b", -1, w);

        // Flush with two lane entries and three infos pending
        flush = 1'b1;
        meta_valid = 1'b1; meta_id = 3'd7; meta_md = 3'd1; meta_cnt = 8'd0; meta_vm = 1'b1;
        drive_beat(rnd256(), '1);
        @(negedge clk);
        chk("t6_flush_meta_ready", 64'(meta_ready), 64'd0);
        chk("t6_flush_seq_ready", 64'(seq_ready), 64'd0);
        chk("t6_flush_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; meta_valid = 1'b0; seq_valid = 1'b0;
        for (int l = 0; l < 4; l++) exp_q[l].delete();
        info_m.delete();
        @(negedge clk);
        chk("t6_post_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6_post_seq_ready", 64'(seq_ready), 64'd0);
        chk("t6_post_meta_ready", 64'(meta_ready), 64'd1);
        chk("t6_post_done", 64'(done), 64'd0);
        @(posedge clk); #1;

        // Normal traffic after flush
        tx_ready = 4'hF;
        send_meta(7, 3, 0, 1, 0);
        drive_beat(ramp(), '1);
        wait_fire("t7", -1, w);
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 4; l++) chk($sformatf("end_lane%0d_pending", l), 64'(exp_q[l].size()), 64'd0);
        chk("end_seq_ready", 64'(seq_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
